// File: rtl/mips_pkg.sv
// mips_pkg: PC-source encodings, NOP, fetch FSM states and default vectors
// shared by the MIPS pipeline front end.
package mips_pkg;
    localparam logic [1:0]  PC_SEQ = 2'b00;
    localparam logic [1:0]  PC_J   = 2'b01;
    localparam logic [1:0]  PC_JR  = 2'b11;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0008;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD,
        ST_DISCARD
    } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register. Priority: flush > hold > load.
// With none of the three asserted it takes a bubble; pc4 is kept across bubbles.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o
);
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        take;

    assign take = load_i && !hold_i && !flush_i;

    always_comb begin
        valid_d = flush_i ? 1'b0 : hold_i ? valid_q : load_i;
        instr_d = flush_i ? NOP : hold_i ? instr_q : take ? instr_i : NOP;
        pc4_d   = take ? pc4_i : pc4_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP;
            pc4_q   <= 32'h0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage - owns the PC, runs the imem handshake and
// feeds IF/ID, redirecting on EX branches and ID jumps/illegal opcodes.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic        legit,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [31:0] epc
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, buf_q, buf_d, pend_q, pend_d, epc_q, epc_d;
    logic [31:0]  pc_plus4, target, ifid_instr, ifid_pc4;
    logic [1:0]   src_eff;
    logic         active, id_ok, id_illegal, id_jump, redirect;
    logic         ifid_flush, ifid_hold, ifid_load;

    assign pc_plus4   = pc_q + 32'd4;
    assign src_eff    = (pc_src == 2'b10) ? PC_SEQ : pc_src;
    assign active     = state_q != ST_BOOT;
    assign id_ok      = active && if_id_valid && !stall && !branch_taken;
    assign id_illegal = id_ok && !legit;
    assign id_jump    = id_ok && legit && (src_eff == PC_J || src_eff == PC_JR);
    assign redirect   = (active && branch_taken) || id_illegal || id_jump;
    assign target     = branch_taken ? branch_target :
                        id_illegal   ? EXC_VECTOR :
                        (src_eff == PC_JR) ? jr_target : jump_target;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_BOOT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:    state_d = ST_FETCH;
            ST_FETCH:   state_d = redirect ? (imem_ready ? ST_FETCH : ST_DISCARD) :
                                  (imem_ready && stall) ? ST_HOLD : ST_FETCH;
            ST_HOLD:    state_d = (redirect || !stall) ? ST_FETCH : ST_HOLD;
            ST_DISCARD: state_d = imem_ready ? ST_FETCH : ST_DISCARD;
            default:    state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        imem_req   = state_q == ST_FETCH || state_q == ST_DISCARD;
        ifid_flush = redirect;
        ifid_hold  = state_q == ST_BOOT || stall;
        ifid_load  = (state_q == ST_FETCH && imem_ready) || state_q == ST_HOLD;
        ifid_instr = (state_q == ST_HOLD) ? buf_q : imem_rdata;
        ifid_pc4   = (state_q == ST_HOLD) ? pc_q : pc_plus4;
    end

    // pend tracks the newest target so a DISCARD ready can use it directly
    always_comb begin
        pend_d = redirect ? target : pend_q;
        buf_d  = (state_q == ST_FETCH && imem_ready && !redirect && stall) ? imem_rdata : buf_q;
        epc_d  = id_illegal ? if_id_pc4 - 32'd4 : epc_q;
        pc_d   = pc_q;
        case (state_q)
            ST_FETCH:   pc_d = !imem_ready ? pc_q : redirect ? target : pc_plus4;
            ST_HOLD:    pc_d = redirect ? target : pc_q;
            ST_DISCARD: pc_d = imem_ready ? pend_d : pc_q;
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= RESET_PC;
            buf_q  <= NOP;
            pend_q <= RESET_PC;
            epc_q  <= 32'h0;
        end else begin
            pc_q   <= pc_d;
            buf_q  <= buf_d;
            pend_q <= pend_d;
            epc_q  <= epc_d;
        end
    end

    assign imem_addr = pc_q;
    assign epc       = epc_q;

    if_id_reg u_if_id (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (ifid_flush),
        .hold_i  (ifid_hold),
        .load_i  (ifid_load),
        .instr_i (ifid_instr),
        .pc4_i   (ifid_pc4),
        .valid_o (if_id_valid),
        .instr_o (if_id_instr),
        .pc4_o   (if_id_pc4)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench; a behavioural fetch model predicts each
// cycle's outputs, a monitor pops and compares after every rising edge.
module tb_fetch_stage;
    localparam logic [31:0] EXC = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        stall = 1'b0, legit = 1'b1, branch_taken = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] jump_target = '0, jr_target = '0, branch_target = '0;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc4, epc;

    fetch_stage dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .pc_src(pc_src),
        .jump_target(jump_target), .jr_target(jr_target),
        .legit(legit), .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .epc(epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: where fetch is, what it holds, and what IF/ID shows.
    logic [31:0] m_pc, m_buf, m_pend, m_epc, m_pc4, m_instr;
    bit          m_valid, m_boot, m_held, m_disc;

    task automatic model_reset();
        m_pc = 32'h0; m_buf = 0; m_pend = 0; m_epc = 0; m_pc4 = 0; m_instr = 0;
        m_valid = 0; m_boot = 1; m_held = 0; m_disc = 0;
    endtask

    function automatic bit m_req();
        return !m_boot && !m_held;
    endfunction

    task automatic model_step();
        bit live, id_ok, bad, jmp, redir, got;
        logic [31:0] tgt;
        live  = !m_boot;
        id_ok = live && m_valid && !stall && !branch_taken;
        bad   = id_ok && !legit;
        jmp   = id_ok && legit && pc_src[0];
        redir = (live && branch_taken) || bad || jmp;
        tgt   = branch_taken ? branch_target : bad ? EXC :
                (pc_src == 2'b11) ? jr_target : jump_target;
        got   = live && !m_held && imem_ready;
        if (bad) m_epc = m_pc4 - 32'd4;
        if (redir) begin
            m_valid = 0; m_instr = 0;
        end else if (live && !stall) begin
            if (m_held) begin
                m_valid = 1; m_instr = m_buf; m_pc4 = m_pc;
            end else if (got && !m_disc) begin
                m_valid = 1; m_instr = imem_rdata; m_pc4 = m_pc + 32'd4;
            end else begin
                m_valid = 0; m_instr = 0;
            end
        end
        if (m_boot) m_boot = 0;
        else if (m_held) begin
            if (redir) m_pc = tgt;
            if (redir || !stall) m_held = 0;
        end else if (m_disc) begin
            if (redir) m_pend = tgt;
            if (got) begin m_pc = m_pend; m_disc = 0; end
        end else if (redir) begin
            if (got) m_pc = tgt;
            else begin m_pend = tgt; m_disc = 1; end
        end else if (got) begin
            if (stall) begin m_buf = imem_rdata; m_held = 1; end
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input bit rdy, input bit st, input bit bt, input logic [31:0] btgt,
                        input logic [1:0] ps, input logic [31:0] jt, input bit lg,
                        input bit force_rdy = 0);
        exp_t e;
        @(negedge clk);
        stall = st; branch_taken = bt; branch_target = btgt;
        pc_src = ps; jump_target = jt; jr_target = $urandom; legit = lg;
        imem_ready = force_rdy || (rdy && m_req());
        imem_rdata = m_pc + 32'h1000;
        model_step();
        e.req = m_req(); e.addr = m_pc; e.valid = m_valid;
        e.instr = m_instr; e.pc4 = m_pc4; e.epc = m_epc;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 0;
        imem_ready = 0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);
        chk("rst_epc", epc, 32'h0);
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1;
        step(1, 0, 0, 0, 2'b00, 0, 1, 1);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("imem_req", {31'b0, imem_req}, {31'b0, e.req});
            chk("imem_addr", imem_addr, e.addr);
            chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
            chk("if_id_instr", if_id_instr, e.instr);
            chk("if_id_pc4", if_id_pc4, e.pc4);
            chk("epc", epc, e.epc);
        end
    end

    initial begin
        do_reset();
        repeat (4) step(1, 0, 0, 0, 2'b00, 0, 1);
        repeat (3) step(1, 1, 0, 0, 2'b00, 0, 1);
        step(0, 0, 0, 0, 2'b00, 0, 1);
        step(1, 0, 0, 0, 2'b00, 0, 1);
        step(1, 1, 0, 0, 2'b01, 32'h40, 1);
        step(1, 0, 0, 0, 2'b00, 0, 1);
        step(1, 0, 0, 0, 2'b01, 32'h40, 1);
        step(1, 0, 0, 0, 2'b00, 0, 1);
        step(0, 0, 1, 32'h100, 2'b00, 0, 1);
        step(0, 0, 0, 0, 2'b00, 0, 1);
        step(1, 0, 0, 0, 2'b00, 0, 1);
        repeat (2) step(1, 0, 0, 0, 2'b00, 0, 1);
        step(1, 0, 0, 0, 2'b00, 0, 0);
        repeat (2) step(1, 0, 0, 0, 2'b00, 0, 1);
        step(1, 0, 1, 32'h200, 2'b00, 0, 0);
        step(1, 0, 0, 0, 2'b10, 32'h77, 1);
        step(1, 0, 0, 0, 2'b11, 0, 1);
        step(0, 0, 1, 32'h300, 2'b00, 0, 1);
        step(0, 0, 0, 0, 2'b00, 0, 1);
        do_reset();
        repeat (3) step(1, 0, 0, 0, 2'b00, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(499) == 0) do_reset();
            else step($urandom_range(3) != 0, $urandom_range(4) == 0, $urandom_range(9) == 0,
                      $urandom, 2'($urandom), $urandom, $urandom_range(11) != 0);
        end
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory request handshake, and loads the IF/ID pipeline register whose instruction field feeds the ID-stage decoder (OpCode = instr[31:26], Funct = instr[5:0]). Consumes the decoder's PCSrc and Legit results plus the EX-stage branch resolution to redirect fetch, and honours stall/flush from the hazard unit.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- EXC_VECTOR, 32'h8000_0008, redirect target for an illegal instruction in ID
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  single-cycle pulse, imem_rdata valid this cycle (may coincide with the first req cycle)
- imem_rdata  in  32  fetched word
- stall  in  1  hazard unit: hold PC and IF/ID
- pc_src  in  2  from ID decoder: 00 sequential, 01 J/JAL, 11 JR/JALR; 10 is treated as 00
- jump_target  in  32  ID: {pc4[31:28], instr[25:0], 2'b00}
- jr_target  in  32  ID: forwarded rs value
- legit  in  1  ID decoder: instruction is legal
- branch_taken  in  1  EX: resolved taken branch
- branch_target  in  32  EX: branch destination
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  32  IF/ID instruction; 32'h0 (NOP) when invalid
- if_id_pc4  out  32  IF/ID PC+4
- epc  out  32  PC of the last illegal instruction

## Operation
- States: BOOT, FETCH, HOLD, DISCARD. Reset → BOOT; pc=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc4=0, epc=0, imem_req=0. BOOT → FETCH unconditionally on the next edge.
- imem_req=1 in FETCH and DISCARD, 0 in BOOT and HOLD; imem_addr=pc at all times.
- Redirect priority: branch_taken (EX) > ID illegal (if_id_valid & ~legit) > ID jump (if_id_valid & pc_src!=00) > sequential. ID redirects are ignored while stall=1 or when branch_taken=1. branch_taken acts regardless of stall.
- Target: branch_target; EXC_VECTOR (also epc <= if_id_pc4-4); jump_target for 01; jr_target for 11.
- Any redirect: IF/ID becomes a bubble (valid=0, instr=0) on the same edge.
- FETCH, ready=1, no redirect, stall=0: IF/ID <= {1, rdata, pc+4}; pc <= pc+4.
- FETCH, ready=1, no redirect, stall=1: buffer <= rdata; pc <= pc+4; → HOLD; IF/ID is held.
- FETCH, ready=0, no redirect: stall=0 → IF/ID bubble; stall=1 → IF/ID held.
- FETCH, redirect, ready=1: rdata dropped; pc <= target; stay in FETCH.
- FETCH, redirect, ready=0: pend <= target; → DISCARD; pc (and therefore imem_addr) unchanged.
- DISCARD: a further redirect overwrites pend. On ready: data dropped, pc <= pend (or the current cycle's target, if a redirect is present), → FETCH. IF/ID loads a bubble when stall=0 and is held when stall=1 (branch flush still applies).
- HOLD: stall=0 → IF/ID <= {1, buffer, pc}, → FETCH. A redirect in HOLD drops the buffer; pc <= target; → FETCH.
- Adders are 32-bit wrap-around; no alignment checking.

## Timing
- Zero-wait memory (ready in the first req cycle): throughput of 1 instruction/cycle. An instruction appears in IF/ID on the edge following its ready.
- Redirect with no outstanding wait: imem_addr equals the target on the cycle after the redirect. With an outstanding wait: imem_addr equals the target on the cycle after the pending ready.
- Reset release: imem_req first asserts 1 cycle after the first clk edge with reset_n=1, with imem_addr=RESET_PC.
- Asserting reset mid-wait abandons the request immediately; a late imem_ready arriving in BOOT is ignored.

## Structure
- Shared package mips_pkg: PCSrc encodings (PC_SEQ=2'b00, PC_J=2'b01, PC_JR=2'b11), NOP=32'h0, fetch state enum, default RESET_PC/EXC_VECTOR.
- One sub-module: if_id_reg (valid/instr/pc4 register with load, hold, and flush-to-bubble controls; flush overrides hold). The FSM, PC, buffer and pend registers live in fetch_stage.

## Test plan
- Reset, zero-wait memory returning addr+32'h1000: imem_addr sequence 0,4,8; IF/ID instr 32'h1000, 32'h1004, 32'h1008 on consecutive cycles with valid=1.
- stall=1 for 3 cycles while ready pulses at 0x8: enter HOLD, imem_req=0; after stall drops, IF/ID = word@0x8, and the next imem_addr is 0xC.
- pc_src=01, jump_target=0x40 with a valid ID instruction: next cycle IF/ID is a bubble and imem_addr=0x40; same stimulus with stall=1 → no redirect.
- A 3-cycle memory wait at 0x10 with branch_taken=1 and branch_target=0x100 in wait cycle 1: imem_addr stays 0x10 until ready, the word is dropped, then imem_addr=0x100.
- legit=0 with branch_taken=0 and if_id_pc4=0x24: epc=0x20, imem_addr=0x8000_0008; with branch_taken=1 in the same cycle, the branch wins and epc is unchanged.
- Assert reset_n=0 during a DISCARD wait: all outputs take their reset values asynchronously; after release, fetch resumes at RESET_PC.
